// File: rtl/seq_mult_ctrl_if.sv
// Start/busy/done handshake and operand/product bus for the sequential multiplier.
// master drives the request; slave is the multiplier unit.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-add multiplier: IDLE/CALC/DONE controller plus accumulator datapath.
// Produces a 2*WIDTH-bit product after WIDTH add/shift iterations; latency is data-independent.
module seq_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  seq_mult_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      counter;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [2*WIDTH-1:0] product_r;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;
  logic               last_iter;

  // The carry of the hi add only lives for one cycle: it is shifted straight into hi[MSB].
  always_comb begin
    sum       = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : '0);
    shifted   = {sum, lo_r[WIDTH-1:1]};
    last_iter = (counter == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      mcand_r   <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand_r <= bus.multiplicand;
            hi_r    <= '0;
            lo_r    <= bus.multiplier;
            counter <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          hi_r    <= shifted[2*WIDTH-1:WIDTH];
          lo_r    <= shifted[WIDTH-1:0];
          counter <= counter + CW'(1);
          if (last_iter) begin
            product_r <= shifted;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state == CALC) || (state == DONE);
  assign bus.done    = (state == DONE);
  assign bus.product = product_r;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: the driver queues expected products, the monitor
// checks each done pulse for product, latency and busy length, and product stability between.
module tb_seq_mult_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seq_mult_ctrl_if #(.WIDTH(W)) bus();

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int unsigned issue;
    int unsigned id;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc      = 0;
  int unsigned checks   = 0;
  int unsigned errors   = 0;
  int unsigned busy_run = 0;
  logic [63:0] last_prod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string nm, input int unsigned id,
                         input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (test %0d): got %h required %h", nm, id, act, req);
    end
  endtask

  // Monitor: compares on every done pulse, otherwise checks the product is held.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_run  = 0;
      last_prod = '0;
    end else begin
      if (bus.busy) busy_run++;
      else          busy_run = 0;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check64("unexpected_done", 0, 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          check64("product", e.id, bus.product, e.prod);
          check64("latency", e.id, 64'(cyc - e.issue), 64'd33);
          check64("busy_len", e.id, 64'(busy_run), 64'd33);
          last_prod = e.prod;
        end
      end else begin
        check64("product_hold", 0, bus.product, last_prod);
      end
    end
  end

  // Drive start for one cycle (called #1 after a posedge); operands are scrambled afterwards.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] req, input int unsigned id);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    sb.push_back('{prod: req, issue: cyc, id: id});
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check64("timeout", 0, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned i0;
    logic [31:0] ra, rb;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check64("reset_busy", 0, 64'(bus.busy), 64'd0);
    check64("reset_done", 0, 64'(bus.done), 64'd0);
    check64("reset_product", 0, bus.product, 64'd0);

    // 1: small operands
    issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1);
    drain(60);

    // 2: all-ones operands exercise the carry-out of the hi add
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2);
    drain(60);

    // 3: zero operands still take the full latency
    issue(32'd0, 32'h1234_5678, 64'd0, 3);
    drain(60);
    issue(32'h1234_5678, 32'd0, 64'd0, 3);
    drain(60);

    // 4: start pulse while busy is ignored
    issue(32'd7, 32'd6, 64'd42, 4);
    repeat (5) @(posedge clk);
    #1;
    bus.start        = 1'b1;
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain(60);
    repeat (40) @(posedge clk);
    #1;

    // 5: reset aborts a multiply in progress
    issue(32'd11, 32'd13, 64'd143, 5);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check64("abort_busy", 5, 64'(bus.busy), 64'd0);
    check64("abort_done", 5, 64'(bus.done), 64'd0);
    check64("abort_product", 5, bus.product, 64'd0);
    issue(32'd2, 32'd8, 64'd16, 5);
    drain(60);

    // 6: start held high back-to-back; second done comes 34 cycles after the first
    bus.start        = 1'b1;
    bus.multiplicand = 32'h0001_0000;
    bus.multiplier   = 32'h0001_0000;
    i0 = cyc;
    sb.push_back('{prod: 64'h0000_0001_0000_0000, issue: i0, id: 6});
    sb.push_back('{prod: 64'd83810205, issue: i0 + 34, id: 6});
    @(posedge clk);
    #1;
    bus.multiplicand = 32'd12345;
    bus.multiplier   = 32'd6789;
    for (int unsigned i = 0; i < 120 && sb.size() != 0; i++) @(posedge clk);
    bus.start = 1'b0;
    if (sb.size() != 0) begin
      check64("timeout", 6, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;

    // 7: random operand pairs against a 64-bit reference product
    for (int unsigned n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      issue(ra, rb, 64'(ra) * 64'(rb), 7);
      drain(60);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
